// File: rtl/bsg_manycore_reg_id_tracker.sv
// bsg_manycore_reg_id_tracker
//
// Decodes the register id carried by a (possibly partial) store request and
// keeps a count of the outstanding requests for every register id. A new
// request is accepted only while its id has fewer than max_out_p requests
// outstanding. The decoded id leaves through a single output register that
// has a ready/valid handshake. Completions retire ids through return_v_i.
//
// Ports
//   clk_i, reset_n_i        clock; asynchronous active-low reset
//   v_i / ready_and_o       request handshake
//   data_i, mask_i          request data and byte mask (1 = lane written)
//   reg_id_i                explicit id, used only when every lane is written
//   v_o / ready_and_i       decoded-id handshake; reg_id_o carries the id
//   return_v_i              retire one outstanding request for return_reg_id_i
//   busy_o                  bit r set while id r has requests outstanding
//   underflow_o             sticky: an id was retired while its count was 0
//   mismatch_o              sticky: the unwritten lanes disagreed on the id
module bsg_manycore_reg_id_tracker #(
  parameter int data_width_p   = 32,
  parameter int reg_id_width_p = 5,
  parameter int max_out_p      = 4,
  localparam int lanes_lp      = data_width_p / 8,
  localparam int regs_lp       = 1 << reg_id_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      ready_and_o,
  input  logic [data_width_p-1:0]   data_i,
  input  logic [lanes_lp-1:0]       mask_i,
  input  logic [reg_id_width_p-1:0] reg_id_i,
  output logic                      v_o,
  output logic [reg_id_width_p-1:0] reg_id_o,
  input  logic                      ready_and_i,
  input  logic                      return_v_i,
  input  logic [reg_id_width_p-1:0] return_reg_id_i,
  output logic [regs_lp-1:0]        busy_o,
  output logic                      underflow_o,
  output logic                      mismatch_o
);

  localparam int cnt_width_lp = $clog2(max_out_p + 1);
  localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_out_p);
  localparam logic [cnt_width_lp-1:0] one_cnt_lp = cnt_width_lp'(1);

  // Only the low reg_id_width_p bits of each lane take part in the decode.
  logic unused_data;
  assign unused_data = ^data_i;

  logic [reg_id_width_p-1:0] decoded_id;
  logic                      lanes_differ;

  // The unwritten lanes of a partial store carry the id. If they disagree,
  // the OR of all of them is still used and the error is flagged.
  always_comb begin
    decoded_id   = '0;
    lanes_differ = 1'b0;
    for (int k = 0; k < lanes_lp; k++) begin
      if (!mask_i[k]) decoded_id = decoded_id | data_i[8*k +: reg_id_width_p];
    end
    // All lanes equal exactly when every lane equals their OR.
    for (int k = 0; k < lanes_lp; k++) begin
      if (!mask_i[k] && (data_i[8*k +: reg_id_width_p] != decoded_id)) lanes_differ = 1'b1;
    end
    if (&mask_i) decoded_id = reg_id_i;
  end

  logic [cnt_width_lp-1:0] count_reg [regs_lp];
  logic                    accept;

  // Never looks at return_v_i: a full id stays blocked until the retirement
  // has actually reached its counter.
  assign ready_and_o = (~v_o | ready_and_i) & (count_reg[decoded_id] < max_cnt_lp);
  assign accept      = v_i & ready_and_o;

  // Output register. An accept while the previous entry drains overwrites it,
  // so a steady stream sees no bubble.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o      <= 1'b0;
      reg_id_o <= '0;
    end else if (accept) begin
      v_o      <= 1'b1;
      reg_id_o <= decoded_id;
    end else if (ready_and_i) begin
      v_o      <= 1'b0;
    end
  end

  // One counter per register id; busy follows the next count so that it
  // matches the counter after every edge.
  for (genvar gi = 0; gi < regs_lp; gi++) begin : g_cnt
    logic                    inc;
    logic                    dec;
    logic [cnt_width_lp-1:0] count_next;

    assign inc = accept && (decoded_id == reg_id_width_p'(gi));
    assign dec = return_v_i && (return_reg_id_i == reg_id_width_p'(gi));

    always_comb begin
      count_next = count_reg[gi];
      if (dec && (count_reg[gi] == '0)) begin
        // Retire with nothing outstanding: the return is dropped.
        count_next = inc ? one_cnt_lp : '0;
      end else if (inc && !dec) begin
        count_next = count_reg[gi] + one_cnt_lp;
      end else if (dec && !inc) begin
        count_next = count_reg[gi] - one_cnt_lp;
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        count_reg[gi] <= '0;
        busy_o[gi]    <= 1'b0;
      end else begin
        count_reg[gi] <= count_next;
        busy_o[gi]    <= (count_next != '0);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      underflow_o <= 1'b0;
      mismatch_o  <= 1'b0;
    end else begin
      if (return_v_i && (count_reg[return_reg_id_i] == '0)) underflow_o <= 1'b1;
      if (accept && lanes_differ) mismatch_o <= 1'b1;
    end
  end

endmodule
